// File: rtl/clock_supervisor.sv
// -----------------------------------------------------------------------------
// clock_supervisor
//
// Sequences a PLL out of reset: pulses the PLL reset, waits for lock, checks
// that lock holds for a stable window, then releases downstream reset. Lock
// loss in RUN restarts the sequence; repeated failed attempts end in a sticky
// FAIL state that only i_reset can leave.
//
// Build option:
//   CLOCK_SUPERVISOR_RETRY_EN  defined   -> failed attempts are retried until
//                                           MAX_RETRIES failures accumulate.
//                              undefined -> the first failed attempt goes to
//                                           FAIL; o_retry_count is tied to 0.
//
// Ports:
//   i_clock        free-running board clock (never a PLL output)
//   i_reset        synchronous active-low reset
//   i_locked       PLL lock flag, asynchronous to i_clock
//   o_pll_reset    active-high reset to the PLL (PLL_RST and FAIL)
//   o_sys_reset    active-high downstream reset, low only in RUN
//   o_ready        high only in RUN
//   o_retry_count  failed attempts since the last entry to RUN
//   o_fail         sticky failure flag, high only in FAIL
// -----------------------------------------------------------------------------
module clock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 125000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_locked,
  output logic       o_pll_reset,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic [3:0] o_retry_count,
  output logic       o_fail
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_N  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  // Terminal values are compared against the incremented count, so a
  // terminal count of zero never occurs.
  localparam logic [CNT_W:0] PLL_N    = PLL_RST_CYCLES[CNT_W:0];
  localparam logic [CNT_W:0] LOCK_N   = LOCK_TIMEOUT[CNT_W:0];
  localparam logic [CNT_W:0] STABLE_N = STABLE_CYCLES[CNT_W:0];
  localparam logic [CNT_W:0] INC_ONE  = {{CNT_W{1'b0}}, 1'b1};

  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("clock_supervisor: MAX_RETRIES must be in 1..15");
  end

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  logic             meta_q;
  logic             locked_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             give_up;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  assign cnt_inc = {1'b0, cnt_q} + INC_ONE;

`ifdef CLOCK_SUPERVISOR_RETRY_EN
  localparam logic [3:0] RETRY_MAX = MAX_RETRIES[3:0];

  logic [3:0] retry_q, retry_d, retry_inc;
  logic       attempt_failed;

  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 4'd1;
  assign give_up   = (retry_inc == RETRY_MAX);

  // Leaving WAIT_LOCK/STABLE for PLL_RST or FAIL only happens on a timeout
  // or a lock glitch, i.e. a failed attempt.
  assign attempt_failed = ((state_q == WAIT_LOCK) || (state_q == STABLE)) &&
                          ((state_d == PLL_RST) || (state_d == FAIL));

  always_comb begin
    retry_d = retry_q;
    if (state_d == RUN) begin
      retry_d = 4'd0;
    end else if (attempt_failed) begin
      retry_d = retry_inc;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      retry_q <= 4'd0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign o_retry_count = retry_q;
`else
  assign give_up       = 1'b1;
  assign o_retry_count = 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_inc == PLL_N) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      WAIT_LOCK: begin
        // The cycle that first sees lock is the first of the stable window.
        if (locked_s_q) begin
          if (STABLE_N == INC_ONE) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d  = STABLE;
            cnt_d    = '0;
            cnt_d[0] = 1'b1;
          end
        end else if (cnt_inc == LOCK_N) begin
          state_d = give_up ? FAIL : PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      STABLE: begin
        if (!locked_s_q) begin
          state_d = give_up ? FAIL : PLL_RST;
          cnt_d   = '0;
        end else if (cnt_inc == STABLE_N) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the same edge.
    pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      meta_q      <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      meta_q      <= i_locked;
      locked_s_q  <= meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign o_pll_reset = pll_reset_q;
  assign o_sys_reset = sys_reset_q;
  assign o_ready     = ready_q;
  assign o_fail      = fail_q;

endmodule

// File: doc/clock_supervisor.md
CLOCK_SUPERVISOR -- requirements
Module: clock_supervisor

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: width of each PLL reset pulse, in i_clock cycles.
REQ-002 Parameter LOCK_TIMEOUT, default 125000: cycles allowed for lock after each PLL reset pulse (1 ms at 125 MHz).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive locked cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 8, range 1..15: failed lock attempts before the FAIL state.
REQ-005 i_clock  input  1  free-running board clock (125 MHz), never a PLL output.
REQ-006 i_reset  input  1  synchronous, active-low reset.
REQ-007 i_locked  input  1  PLL locked flag, asynchronous to i_clock.
REQ-008 o_pll_reset  output  1  active-high reset driven to the PLL reset pin.
REQ-009 o_sys_reset  output  1  active-high reset for downstream logic; high unless in RUN.
REQ-010 o_ready  output  1  high only in RUN.
REQ-011 o_retry_count  output  4  failed attempts since the last entry to RUN.
REQ-012 o_fail  output  1  sticky failure flag; high only in FAIL.

Function
REQ-013 i_locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-014 The FSM SHALL have exactly five states: PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL; all outputs are registered and change on the same edge the state changes.
REQ-015 PLL_RST: o_pll_reset=1; after PLL_RST_CYCLES cycles, go to WAIT_LOCK and clear the cycle counter.
REQ-016 WAIT_LOCK: o_pll_reset=0. If locked_s=1, go to STABLE. If LOCK_TIMEOUT cycles elapse without lock, it is a failed attempt (REQ-019).
REQ-017 STABLE: the counter counts consecutive locked_s=1 cycles. On reaching STABLE_CYCLES, go to RUN. If locked_s=0 in any cycle, it is a failed attempt (glitch).
REQ-018 RUN: o_sys_reset=0, o_ready=1, retry count cleared on entry. If locked_s=0, go to PLL_RST without incrementing the retry count.
REQ-019 Failed attempt: increment the retry count. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
REQ-020 FAIL: o_fail=1, o_pll_reset=1, o_sys_reset=1, o_ready=0; the only exit is i_reset.
REQ-021 Latency: o_ready SHALL rise exactly 2+STABLE_CYCLES edges after i_locked is first sampled high in WAIT_LOCK. o_ready SHALL fall exactly 3 edges after i_locked falls in RUN.
REQ-022 Outputs in every state other than RUN: o_sys_reset=1 and o_ready=0.
REQ-023 The retry count SHALL saturate at MAX_RETRIES and never wrap.
REQ-024 Counter widths SHALL be sized by $clog2 of the largest parameter; a count of 0 is never used as a terminal value.

Reset
REQ-025 When i_reset=0 at an edge: state=PLL_RST, counters=0, synchronizer flops=0, o_pll_reset=1, o_sys_reset=1, o_ready=0, o_retry_count=0, o_fail=0.
REQ-026 Reset SHALL dominate every other event in every state, including FAIL and mid-count.
REQ-027 PLL_RST timing SHALL restart from zero on the first edge with i_reset=1.

Configuration
REQ-028 With the macro CLOCK_SUPERVISOR_RETRY_EN defined, failed attempts retry per REQ-019.
REQ-029 Without CLOCK_SUPERVISOR_RETRY_EN, the first failed attempt SHALL go directly to FAIL, o_retry_count is tied to 0, and the retry counter logic is absent.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, macro defined unless stated)
REQ-030 Reset release, i_locked rises 10 cycles later and stays high -> o_pll_reset high for the first 4 cycles; o_ready and o_sys_reset=0 exactly 10 edges after the rise; o_retry_count=0.
REQ-031 i_locked held 0 -> three o_pll_reset pulses, 4 cycles each, 24 cycles apart; after the third timeout o_fail=1, o_retry_count=3, o_pll_reset stays 1.
REQ-032 1-cycle i_locked low pulse during STABLE cycle 5 -> return to PLL_RST, o_retry_count=1, o_ready never asserts; with i_locked then held high, RUN is reached and the count clears to 0.
REQ-033 i_locked falls in RUN -> o_ready=0, o_sys_reset=1 and o_pll_reset=1 exactly 3 edges later; o_retry_count stays 0.
REQ-034 i_reset=0 for one cycle while in FAIL, and separately mid-STABLE -> next edge shows all REQ-025 values.
REQ-035 Macro undefined, i_locked held 0 -> o_fail=1 at the first timeout (edge 24), o_retry_count=0.
